// File: rtl/freq_meter.sv
// Frequency and period meter: counts synchronized rising edges of sig_in per
// gate window and measures the clk-cycle spacing between successive edges.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 48000000,
    parameter int unsigned COUNT_W     = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    output logic               count_ovf,
    output logic [COUNT_W-1:0] period,
    output logic               period_valid
);

    localparam int unsigned GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);

    localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [SETTLE_W-1:0]    r_settle;
    logic [GATE_W-1:0]      r_gate;
    logic [COUNT_W-1:0]     r_edges;
    logic                   r_ovf;
    logic [COUNT_W-1:0]     r_pcnt;
    logic                   r_armed;

    logic                   w_settled;
    logic                   w_edge;
    logic                   w_terminal;
    logic                   w_edges_full;
    logic [COUNT_W-1:0]     w_edges_next;
    logic                   w_ovf_next;

    // Edges are masked until the settle counter saturates so a level held
    // across reset release is never mistaken for a rising edge.
    assign w_settled    = (r_settle == SETTLE_DONE);
    assign w_edge       = r_sync[SYNC_STAGES-1] & ~r_prev & w_settled;
    assign w_terminal   = (r_gate == GATE_LAST);
    assign w_edges_full = &r_edges;
    assign w_edges_next = (w_edge && !w_edges_full) ? r_edges + COUNT_W'(1) : r_edges;
    assign w_ovf_next   = r_ovf | (w_edge & w_edges_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_prev   <= 1'b0;
            r_settle <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (!w_settled) begin
                r_settle <= r_settle + SETTLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gate <= '0;
        end else if (w_terminal) begin
            r_gate <= '0;
        end else begin
            r_gate <= r_gate + GATE_W'(1);
        end
    end

    // The terminal cycle publishes the total including its own edge, then
    // restarts the accumulation so consecutive windows abut.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edges     <= '0;
            r_ovf       <= 1'b0;
            count       <= '0;
            count_ovf   <= 1'b0;
            count_valid <= 1'b0;
        end else if (w_terminal) begin
            count       <= w_edges_next;
            count_ovf   <= w_ovf_next;
            count_valid <= 1'b1;
            r_edges     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_edges     <= w_edges_next;
            r_ovf       <= w_ovf_next;
            count_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_armed      <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (w_edge) begin
                r_pcnt  <= COUNT_W'(1);
                r_armed <= 1'b1;
                if (r_armed) begin
                    period       <= r_pcnt;
                    period_valid <= 1'b1;
                end
            end else if (!(&r_pcnt)) begin
                r_pcnt <= r_pcnt + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: 8-bit and 4-bit instances share clk, rst, sig_in.
module tb_freq_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig_in;

    logic [7:0] c8, p8;
    logic       cv8, ov8, pv8;
    logic [3:0] c4, p4;
    logic       cv4, ov4, pv4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(100), .COUNT_W(8), .SYNC_STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .count(c8), .count_valid(cv8), .count_ovf(ov8),
        .period(p8), .period_valid(pv8)
    );

    freq_meter #(.GATE_CYCLES(100), .COUNT_W(4), .SYNC_STAGES(2)) u_dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .count(c4), .count_valid(cv4), .count_ovf(ov4),
        .period(p4), .period_valid(pv4)
    );

    typedef struct {
        int half;
        int exp_count;
        int exp_period;
        int exp_npv;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Release lands on a negedge; the cycle after the next posedge is cycle 1.
    task automatic do_reset(input logic s);
        rst    = 1'b1;
        sig_in = s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_c8"},  c8,  0);
        check({tag, "_cv8"}, cv8, 0);
        check({tag, "_ov8"}, ov8, 0);
        check({tag, "_p8"},  p8,  0);
        check({tag, "_pv8"}, pv8, 0);
        check({tag, "_c4"},  c4,  0);
        check({tag, "_cv4"}, cv4, 0);
        check({tag, "_ov4"}, ov4, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   n, npv;
        int   exp_b[3];
        int   exp_o4[3], exp_v4[3], exp_o8[3];
        int   exp_h[3];
        int   exp_ps[2];

        vecs[0] = '{5,  10, 10, 34};
        vecs[1] = '{2,  25, 4,  86};
        vecs[2] = '{10, 5,  20, 16};
        vecs[3] = '{1,  50, 2,  173};
        vecs[4] = '{25, 2,  50, 6};

        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Square waves: window 1 may be short of edges, later ones must be exact.
        for (int v = 0; v < 5; v++) begin
            do_reset(1'b0);
            n   = 0;
            npv = 0;
            for (int k = 0; k < 350; k++) begin
                tick;
                if (cv8) begin
                    n++;
                    check("sq_win_align", cyc % 100, 0);
                    if (n >= 2) begin
                        check("sq_count", c8, vecs[v].exp_count);
                        check("sq_ovf", ov8, 0);
                    end
                end
                if (pv8) begin
                    npv++;
                    check("sq_period", p8, vecs[v].exp_period);
                end
                sig_in = ((cyc / vecs[v].half) % 2) == 1;
            end
            check("sq_windows", n, 3);
            check("sq_npv", npv, vecs[v].exp_npv);
        end

        // Edges flagged in cycle 99 (terminal) and cycle 200 (first of window 3).
        exp_b = '{1, 0, 1};
        do_reset(1'b0);
        n   = 0;
        npv = 0;
        for (int k = 0; k < 350; k++) begin
            tick;
            if (cv8) begin
                if (n < 3) check("bnd_count", c8, exp_b[n]);
                n++;
            end
            if (pv8) begin
                npv++;
                check("bnd_period", p8, 101);
            end
            sig_in = (cyc >= 97 && cyc < 150) || (cyc >= 198);
        end
        check("bnd_windows", n, 3);
        check("bnd_npv", npv, 1);

        // clk/2 toggling saturates the 4-bit counter, then 3 sparse edges.
        exp_v4 = '{15, 15, 3};
        exp_o4 = '{1, 1, 0};
        exp_o8 = '{49, 50, 3};
        do_reset(1'b0);
        n = 0;
        for (int k = 0; k < 305; k++) begin
            tick;
            if (cv4) begin
                if (n < 3) begin
                    check("ovf_count4", c4, exp_v4[n]);
                    check("ovf_flag4", ov4, exp_o4[n]);
                    check("ovf_count8", c8, exp_o8[n]);
                    check("ovf_flag8", ov8, 0);
                end
                n++;
            end
            if (cyc < 198) sig_in = (cyc % 2) == 1;
            else sig_in = (cyc >= 220 && cyc < 230) || (cyc >= 240 && cyc < 250) ||
                          (cyc >= 260 && cyc < 270);
        end
        check("ovf_windows", n, 3);

        // Held high across release: no edge until a real low->high at flag 262.
        exp_h = '{0, 0, 1};
        do_reset(1'b1);
        n   = 0;
        npv = 0;
        for (int k = 0; k < 350; k++) begin
            tick;
            if (cv8) begin
                if (n < 3) check("hold_count", c8, exp_h[n]);
                n++;
            end
            if (pv8) npv++;
            sig_in = !(cyc >= 250 && cyc < 260);
        end
        check("hold_windows", n, 3);
        check("hold_npv", npv, 0);

        // Flags at 12, 312, 566: first gap saturates, second is just below.
        exp_ps = '{255, 254};
        do_reset(1'b0);
        npv = 0;
        for (int k = 0; k < 600; k++) begin
            tick;
            if (pv8) begin
                if (npv < 2) check("psat_period", p8, exp_ps[npv]);
                npv++;
            end
            sig_in = (cyc >= 10 && cyc < 20) || (cyc >= 310 && cyc < 320) ||
                     (cyc >= 564 && cyc < 574);
        end
        check("psat_npv", npv, 2);

        // Reset at cycle 50 of window 2 with edges already accumulated.
        do_reset(1'b0);
        for (int k = 0; k < 150; k++) begin
            tick;
            if (cv8) check("mid_pre_count", c8, 10);
            sig_in = ((cyc / 5) % 2) == 1;
        end
        check("mid_hold_count", c8, 10);
        check("mid_hold_period", p8, 10);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        for (int k = 0; k < 3; k++) begin
            tick;
            check("mid_rst_cv", cv8, 0);
            check("mid_rst_pv", pv8, 0);
        end
        sig_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        n   = 0;
        npv = 0;
        for (int k = 0; k < 150; k++) begin
            tick;
            if (cv8) begin
                n++;
                check("mid_first_cv", cyc, 100);
                check("mid_post_count", c8, 3);
            end
            if (pv8) begin
                npv++;
                check("mid_post_period", p8, 20);
            end
            sig_in = (cyc >= 10 && cyc < 20) || (cyc >= 30 && cyc < 40) ||
                     (cyc >= 50 && cyc < 60);
        end
        check("mid_windows", n, 1);
        check("mid_npv", npv, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
